// File: rtl/sram_pkg.sv
// Shared definitions for the lab SRAM bus responder: default geometry,
// sweep value, controller states and the last-address helper.
package sram_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_CLEAR_VAL = 0;

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    function automatic int unsigned last_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    localparam int unsigned LAST_ADDR = last_addr(DEF_ADDR_W);

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous RAM with a registered read port that only
// updates on an enabled read, so the output holds across writes and idles.
module sram_array #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // NOTE: storage has no reset; it maps onto a RAM macro and the post-reset sweep gives known contents.
    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Bus target: captures each request one edge, commits it to the array the
// next edge, and sweeps CLEAR_VAL through the whole array after reset.
module sram_responder
    import sram_pkg::*;
#(
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter int                 DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = DATA_W'(DEF_CLEAR_VAL)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              n_write,
    input  logic              n_output,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              data_oe,
    output logic              ready,
    output logic              conflict,
    output logic              dropped
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(last_addr(ADDR_W));

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_addr;

    logic              cap_wr, cap_rd, cap_conf;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cap_addr;
        mem_din    = cap_data;
        case (state)
            CLEAR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                mem_din  = CLEAR_VAL;
                if (clr_addr == LAST) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                mem_en = cap_wr | cap_rd;
                mem_we = cap_wr;
            end
        endcase
        // A write still sitting in the capture stage at a reset edge is dropped.
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cap_wr   <= 1'b0;
            cap_rd   <= 1'b0;
            cap_conf <= 1'b0;
            rd_valid <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            rd_valid <= cap_rd;
            conflict <= cap_conf;
            if (state == CLEAR && (!n_write || !n_output)) begin
                dropped <= 1'b1;
            end
            if (state == SERVE) begin
                cap_wr   <= ~n_write;
                cap_rd   <= ~n_output & n_write;
                cap_conf <= ~n_write & ~n_output;
            end
        end
    end

    // Payload is qualified by cap_wr/cap_rd, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state == SERVE) begin
            cap_addr <= addr;
            cap_data <= wr_data;
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .rst   (rst),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .din   (mem_din),
        .dout  (rd_data)
    );

    assign ready   = (state == SERVE);
    assign data_oe = rd_valid;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: clear sweep timing, pipelined
// read/write traffic, hazards, conflicts, dropped requests and reset.
module tb_sram_responder;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] addr = '0;
    logic        n_write = 1'b1;
    logic        n_output = 1'b1;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_valid, data_oe, ready, conflict, dropped;

    int vectors = 0;
    int errs = 0;

    sram_responder dut (
        .clock    (clock),
        .rst      (rst),
        .addr     (addr),
        .n_write  (n_write),
        .n_output (n_output),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .data_oe  (data_oe),
        .ready    (ready),
        .conflict (conflict),
        .dropped  (dropped)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Inputs change on the falling edge; outputs seen here reflect all prior rising edges.
    task automatic put(input logic nw, input logic no, input logic [10:0] a, input logic [15:0] d);
        @(negedge clock);
        n_write  = nw;
        n_output = no;
        addr     = a;
        wr_data  = d;
    endtask

    task automatic idle();
        put(1'b1, 1'b1, 11'd0, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        n_write = 1'b1;
        n_output = 1'b1;
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 3000) begin
            idle();
            n++;
        end
    endtask

    task automatic read_word(input logic [10:0] a, output logic [15:0] d,
                             output logic v, output logic oe, output logic v_after);
        put(1'b1, 1'b0, a, 16'h0000);
        idle();
        idle();
        d  = rd_data;
        v  = rd_valid;
        oe = data_oe;
        idle();
        v_after = rd_valid;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        vectors++;
        if ({rd_data, rd_valid, data_oe, ready, conflict, dropped} !== 21'h0) begin
            errs++;
            $display("FAIL reset_values: got rd_data=%h valid=%b oe=%b ready=%b conflict=%b dropped=%b, want all 0",
                     rd_data, rd_valid, data_oe, ready, conflict, dropped);
        end
        wait_ready(n);
        vectors++;
        if (n !== 2048) begin
            errs++;
            $display("FAIL clear_length: ready after %0d edges, want 2048", n);
        end
    endtask

    task automatic test_clear_reads();
        logic [10:0] addrs [4] = '{11'd0, 11'd1, 11'd1000, 11'd2047};
        logic [15:0] d;
        logic v, oe, va;
        foreach (addrs[i]) begin
            read_word(addrs[i], d, v, oe, va);
            vectors++;
            if (d !== 16'h0000 || v !== 1'b1 || oe !== 1'b1 || va !== 1'b0) begin
                errs++;
                $display("FAIL clear_read[%0d]: got data=%h valid=%b oe=%b next_valid=%b, want 0000 1 1 0",
                         addrs[i], d, v, oe, va);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 127; i++) begin
            put(1'b0, 1'b1, 11'(i), 16'(127 - i));
        end
        for (int i = 0; i < 130; i++) begin
            if (i < 127) put(1'b1, 1'b0, 11'(i), 16'h0000);
            else         idle();
            if (i == 1) begin
                vectors++;
                if (rd_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_write_valid: rd_valid=%b on write commit, want 0", rd_valid);
                end
            end else if (i >= 2 && i <= 128) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== 16'(129 - i)) begin
                    errs++;
                    $display("FAIL b2b_read[%0d]: got data=%0d valid=%b, want %0d 1",
                             i - 2, rd_data, rd_valid, 129 - i);
                end
            end else if (i == 129) begin
                vectors++;
                if (rd_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_tail_valid: rd_valid=%b after last read, want 0", rd_valid);
                end
            end
        end
    endtask

    task automatic test_hazard();
        put(1'b0, 1'b1, 11'd5, 16'hBEEF);
        put(1'b1, 1'b0, 11'd5, 16'h0000);
        idle();
        idle();
        vectors++;
        if (rd_data !== 16'hBEEF || rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL raw_hazard: got data=%h valid=%b, want beef 1", rd_data, rd_valid);
        end
        put(1'b0, 1'b1, 11'd6, 16'h1111);
        idle();
        idle();
        vectors++;
        if (rd_data !== 16'hBEEF || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL hold_on_write: got data=%h valid=%b, want beef 0", rd_data, rd_valid);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] d;
        logic v, oe, va;
        put(1'b0, 1'b0, 11'd9, 16'h1234);
        idle();
        idle();
        vectors++;
        if (conflict !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL conflict_pulse: got conflict=%b valid=%b, want 1 0", conflict, rd_valid);
        end
        idle();
        vectors++;
        if (conflict !== 1'b0) begin
            errs++;
            $display("FAIL conflict_width: conflict=%b one cycle later, want 0", conflict);
        end
        read_word(11'd9, d, v, oe, va);
        vectors++;
        if (d !== 16'h1234 || v !== 1'b1) begin
            errs++;
            $display("FAIL conflict_write: got data=%h valid=%b, want 1234 1", d, v);
        end
    endtask

    task automatic test_dropped();
        int n;
        logic [15:0] d;
        logic v, oe, va;
        do_reset();
        n = 0;
        while (!ready && n < 3000) begin
            if (n == 2) put(1'b0, 1'b1, 11'd20, 16'h5555);
            else        idle();
            n++;
            if (n == 3 || n == 4) begin
                vectors++;
                if (dropped !== (n == 4)) begin
                    errs++;
                    $display("FAIL dropped_edge%0d: dropped=%b, want %b", n, dropped, n == 4);
                end
            end
        end
        vectors++;
        if (n !== 2048 || dropped !== 1'b1) begin
            errs++;
            $display("FAIL dropped_sticky: ready after %0d edges dropped=%b, want 2048 1", n, dropped);
        end
        read_word(11'd20, d, v, oe, va);
        vectors++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            errs++;
            $display("FAIL dropped_ignored: got data=%h valid=%b, want 0000 1", d, v);
        end
        do_reset();
        vectors++;
        if (dropped !== 1'b0 || ready !== 1'b0 || rd_data !== 16'h0000) begin
            errs++;
            $display("FAIL rereset: got dropped=%b ready=%b rd_data=%h, want 0 0 0000", dropped, ready, rd_data);
        end
        wait_ready(n);
        vectors++;
        if (n !== 2048) begin
            errs++;
            $display("FAIL reclear_length: ready after %0d edges, want 2048", n);
        end
    endtask

    task automatic test_reset_discard();
        int n;
        logic [15:0] d;
        logic v, oe, va;
        put(1'b0, 1'b1, 11'd3, 16'hAAAA);
        do_reset();
        wait_ready(n);
        read_word(11'd3, d, v, oe, va);
        vectors++;
        if (d !== 16'h0000 || v !== 1'b1 || n !== 2048) begin
            errs++;
            $display("FAIL reset_discard: got data=%h valid=%b clear_edges=%0d, want 0000 1 2048", d, v, n);
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_back_to_back();
        test_hazard();
        test_conflict();
        test_dropped();
        test_reset_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
